// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the requesting units and the shared result mux arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface mux_rr_arbiter_if #(
   parameter int SEL_WID = 4
);
   localparam int N_REQ = 2 ** SEL_WID;

   logic [N_REQ-1:0]   req;
   logic               rel;
   logic [N_REQ-1:0]   gnt;
   logic [SEL_WID-1:0] sel;
   logic               sel_valid;
   logic               timeout;

   modport master (
      output req, rel,
      input  gnt, sel, sel_valid, timeout
   );

   modport slave (
      input  req, rel,
      output gnt, sel, sel_valid, timeout
   );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the 16:1 result mux: one-hot grant, registered select,
// hold timeout, and a mandatory one-cycle bubble between owners.
module mux_rr_arbiter #(
   parameter int SEL_WID  = 4,
   parameter int MAX_HOLD = 64,
   parameter int CNT_WID  = 8
) (
   input logic          clk,
   input logic          rst_n,
   mux_rr_arbiter_if.slave bus
);
   localparam int N_REQ = 2 ** SEL_WID;
   localparam logic [CNT_WID-1:0] HOLD_LAST = CNT_WID'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);

   localparam logic [0:0] ST_ARB = 1'b0;
   localparam logic [0:0] ST_OWN = 1'b1;

   logic [0:0]         state;
   logic [SEL_WID-1:0] ptr;
   logic [CNT_WID-1:0] hold_cnt;
   logic [N_REQ-1:0]   gnt_q;
   logic [SEL_WID-1:0] sel_q;
   logic               sel_valid_q;
   logic               timeout_q;

   logic               found;
   logic [SEL_WID-1:0] win;
   logic [SEL_WID-1:0] idx;
   logic               owner_done;
   logic               hold_expired;

   // Scan starts at ptr; SEL_WID-bit addition gives the modulo-N_REQ wrap for free.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = ptr + SEL_WID'(k);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // In OWN, sel_q always holds the owner index.
   assign owner_done   = bus.rel || !bus.req[sel_q];
   assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_ARB;
         ptr         <= '0;
         hold_cnt    <= '0;
         gnt_q       <= '0;
         sel_q       <= '0;
         sel_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            ST_ARB: begin
               if (found) begin
                  state       <= ST_OWN;
                  gnt_q       <= N_REQ'(1) << win;
                  sel_q       <= win;
                  sel_valid_q <= 1'b1;
                  hold_cnt    <= '0;
               end
            end
            ST_OWN: begin
               if (owner_done || hold_expired) begin
                  state       <= ST_ARB;
                  gnt_q       <= '0;
                  sel_valid_q <= 1'b0;
                  ptr         <= sel_q + 1'b1;
                  timeout_q   <= !owner_done;
               end else if (MAX_HOLD != 0 && hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state       <= ST_ARB;
               gnt_q       <= '0;
               sel_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.sel       = sel_q;
   assign bus.sel_valid = sel_valid_q;
   assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with a cycle-level reference model and literal spot checks.
module tb_mux_rr_arbiter;
   localparam int SEL_WID  = 4;
   localparam int N_REQ    = 16;
   localparam int MAX_HOLD = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mux_rr_arbiter_if #(.SEL_WID(SEL_WID)) bus();

   mux_rr_arbiter #(.SEL_WID(SEL_WID), .MAX_HOLD(MAX_HOLD), .CNT_WID(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owner index (-1 = nobody), last select, rotation pointer, cycles held.
   int m_owner;
   int m_sel;
   int m_ptr;
   int m_hold;
   bit m_to;
   int m_pick;

   function automatic int rr_pick(input logic [N_REQ-1:0] r, input int start);
      for (int k = 0; k < N_REQ; k++) begin
         if (r[(start + k) % N_REQ]) return (start + k) % N_REQ;
      end
      return -1;
   endfunction

   always_comb m_pick = rr_pick(bus.req, m_ptr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= -1;
         m_sel   <= 0;
         m_ptr   <= 0;
         m_hold  <= 0;
         m_to    <= 1'b0;
      end else begin
         m_to <= 1'b0;
         if (m_owner < 0) begin
            if (m_pick >= 0) begin
               m_owner <= m_pick;
               m_sel   <= m_pick;
               m_hold  <= 0;
            end
         end else if (bus.rel || !bus.req[m_owner]) begin
            m_owner <= -1;
            m_ptr   <= (m_owner + 1) % N_REQ;
         end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD - 1) begin
            m_owner <= -1;
            m_ptr   <= (m_owner + 1) % N_REQ;
            m_to    <= 1'b1;
         end else begin
            m_hold <= m_hold + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      logic [N_REQ-1:0] eg;
      eg = (m_owner < 0) ? '0 : (N_REQ'(1) << m_owner);
      chk("model_gnt", 32'(bus.gnt), 32'(eg));
      chk("model_sel", 32'(bus.sel), 32'(m_sel));
      chk("model_sel_valid", 32'(bus.sel_valid), 32'(m_owner >= 0));
      chk("model_timeout", 32'(bus.timeout), 32'(m_to));
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      bus.req = '0;
      bus.rel = 1'b0;

      // 1: reset and idle
      step(2);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("idle_gnt", 32'(bus.gnt), 32'h0);
         chk("idle_sel_valid", 32'(bus.sel_valid), 32'h0);
      end
      chk("idle_sel", 32'(bus.sel), 32'h0);
      chk("idle_timeout", 32'(bus.timeout), 32'h0);

      // 2: two requesters, release in the third OWN cycle
      bus.req = 16'h0009;
      step(1);
      chk("t2_first_gnt", 32'(bus.gnt), 32'h0001);
      chk("t2_first_sel", 32'(bus.sel), 32'h0);
      step(2);
      bus.rel = 1'b1;
      step(1);
      bus.rel = 1'b0;
      chk("t2_bubble_gnt", 32'(bus.gnt), 32'h0);
      chk("t2_bubble_sel", 32'(bus.sel), 32'h0);
      step(1);
      chk("t2_second_gnt", 32'(bus.gnt), 32'h0008);
      chk("t2_second_sel", 32'(bus.sel), 32'h3);
      bus.req = 16'h0000;
      step(1);
      chk("t2_drop_gnt", 32'(bus.gnt), 32'h0);

      // 3: wrap-around from owner 15
      bus.req = 16'h8000;
      step(1);
      chk("t3_owner15_gnt", 32'(bus.gnt), 32'h8000);
      bus.req = 16'h8001;
      bus.rel = 1'b1;
      step(1);
      bus.rel = 1'b0;
      chk("t3_bubble_gnt", 32'(bus.gnt), 32'h0);
      chk("t3_bubble_sel", 32'(bus.sel), 32'hF);
      step(1);
      chk("t3_wrap_gnt", 32'(bus.gnt), 32'h0001);
      chk("t3_wrap_sel", 32'(bus.sel), 32'h0);
      bus.req = 16'h0000;
      step(1);

      // 4: hold timeout with a lone requester
      bus.req = 16'h0020;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("t4_hold_gnt", 32'(bus.gnt), 32'h0020);
         chk("t4_hold_timeout", 32'(bus.timeout), 32'h0);
      end
      step(1);
      chk("t4_revoke_gnt", 32'(bus.gnt), 32'h0);
      chk("t4_revoke_timeout", 32'(bus.timeout), 32'h1);
      step(1);
      chk("t4_regrant_gnt", 32'(bus.gnt), 32'h0020);
      chk("t4_regrant_timeout", 32'(bus.timeout), 32'h0);

      // 5: release in the last permitted OWN cycle beats the timeout
      step(3);
      chk("t5_fourth_gnt", 32'(bus.gnt), 32'h0020);
      bus.rel = 1'b1;
      bus.req = 16'h0000;
      step(1);
      bus.rel = 1'b0;
      chk("t5_release_gnt", 32'(bus.gnt), 32'h0);
      chk("t5_release_timeout", 32'(bus.timeout), 32'h0);
      step(1);
      chk("t5_after_timeout", 32'(bus.timeout), 32'h0);

      // 6: asynchronous reset mid-grant, then pointer restarts at 0
      bus.req = 16'h0010;
      step(1);
      chk("t6_owner_gnt", 32'(bus.gnt), 32'h0010);
      chk("t6_owner_sel", 32'(bus.sel), 32'h4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_gnt", 32'(bus.gnt), 32'h0);
      chk("t6_async_sel", 32'(bus.sel), 32'h0);
      chk("t6_async_sel_valid", 32'(bus.sel_valid), 32'h0);
      bus.req = 16'h0044;
      step(2);
      rst_n = 1'b1;
      step(1);
      chk("t6_ptr_gnt", 32'(bus.gnt), 32'h0004);
      chk("t6_ptr_sel", 32'(bus.sel), 32'h2);
      bus.req = 16'h0000;
      step(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
